decode_stage: RTL
=================

# decode_stage

Pipelined, parametrised instruction-decode stage for the rv32i core, placed between fetch and register-read/execute. It takes one instruction word plus PC per valid/ready handshake. It classifies the instruction format from the opcode, produces a single sign-extended immediate for that format, and flags illegal encodings. It also emits register-use qualifiers. Output is registered behind a 2-entry skid buffer, so the stage sustains one instruction per cycle under backpressure.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; immediate and PC are XLEN wide
- SKID, 1, 1 = 2-entry skid buffer (full throughput, in_ready registered); 0 = single register, in_ready = !full || out_ready
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  instruction offered
- in_ready  output  1  stage accepts this cycle
- in_instr  input  32  instruction word
- in_pc  input  XLEN  PC of instruction
- out_valid  output  1  decoded entry available
- out_ready  input  1  consumer accepts
- out_pc  output  XLEN  passed-through PC
- out_opcode / out_funct3 / out_funct7  output  7/3/7  raw fields
- out_rs1 / out_rs2 / out_rd  output  5 each  register indices
- out_fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
- out_imm  output  XLEN  sign-extended immediate; 0 for R and ILLEGAL
- out_rs1_used / out_rs2_used / out_rd_written  output  1 each  register-use qualifiers
- out_illegal  output  1  unsupported encoding

## Operation
- Transfer on the input when in_valid && in_ready. Transfer on the output when out_valid && out_ready.
- Opcode map:
  - 0110111 LUI, 0010111 AUIPC: U
  - 1101111 JAL: J
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM: I
  - 0100011 STORE: S
  - 1100011 BRANCH: B
  - 0110011 OP: R
  - anything else: ILLEGAL, out_illegal=1
- Immediates, sign bit is instr[31], extended to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- rs1_used: R, I, S, B. rs2_used: R, S, B. rd_written: R, I, U, J and rd != 0. All qualifiers are 0 when ILLEGAL.
- An illegal entry is still delivered, in order, so the downstream stage can raise the exception. The stage never drops it.
- Buffering (SKID=1):
  - Main register plus skid register.
  - An accept while the main register is occupied and not draining goes to the skid register.
  - When the main register drains, the skid entry moves to main.
  - in_ready = !skid_valid, registered.
- Order is strictly FIFO. Simultaneous accept and drain with one entry held: the new entry replaces main, count unchanged.
- flush: both valid bits clear next cycle. An input offered in the flush cycle is discarded, with in_ready asserted so fetch does not stall.

## Timing
- Latency: accepted at edge N, visible on out_* after edge N (same cycle as the accepting edge's result), i.e. 1-cycle registered.
- Throughput: 1/cycle with out_ready held high, both SKID settings.
- Reset values:
  - out_valid=0, skid valid=0, in_ready=1
  - out_fmt=7, out_illegal=0, all other out_* = 0
- out_* hold stable while out_valid && !out_ready. The payload is don't-care while out_valid=0, but the bench checks that it holds its reset value until the first accept.
- Reset or flush mid-stream wins over any simultaneous transfer.
- Full: with 2 entries held and out_ready=0, in_ready=0 until a drain occurs. The entry accepted on the cycle in_ready rises is lossless.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams
  - format encoding constants (FMT_R … FMT_ILLEGAL)
  - the XLEN default
- Sub-module decode_imm_gen: combinational, instr in, {fmt, imm, illegal, use flags} out, parameter XLEN. The stage wraps it with the skid buffer and handshake logic.

## Test plan
- addi x1,x0,-1 (0xFFF00093), XLEN=32 → fmt=1, imm=0xFFFFFFFF, rd=1, rd_written=1, rs2_used=0; same word with XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
- sw x1,12(x2) (0x00112623) → fmt=2, imm=12, rs1=2, rs2=1, rd_written=0; beq x0,x0,-4 (0xFE000EE3) → fmt=3, imm=0xFFFFFFFC.
- lui x5,0x12345 (0x123452B7) → fmt=4, imm=0x12345000, rd=5; 0x00000000 → fmt=7, illegal=1, imm=0, all use flags 0, still delivered.
- Backpressure: three instructions offered back-to-back, out_ready=0 for 3 cycles → in_ready falls after 2 accepts; after out_ready=1 all three emerge in order, then 1/cycle.
- flush asserted with 2 entries held and in_valid=1 → next cycle out_valid=0, in_ready=1, nothing from before or during the flush emerges.
- reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, in_ready=1, out_fmt=7.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i decode constants: opcodes, format codes and datapath default.
package rv32i_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    localparam logic [2:0] FMT_R       = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    // Instruction format implied by the major opcode.
    function automatic logic [2:0] fmt_of(input logic [6:0] opcode);
        logic [2:0] fmt;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                       fmt = FMT_U;
            OPC_JAL:                                  fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:                 fmt = FMT_I;
            OPC_STORE:                                fmt = FMT_S;
            OPC_BRANCH:                               fmt = FMT_B;
            OPC_OP:                                   fmt = FMT_R;
            default:                                  fmt = FMT_ILLEGAL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if import rv32i_pkg::*; #(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_written;
    logic            out_illegal;

    // Environment side: fetch producer and execute consumer.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_fmt, out_imm,
               out_rs1_used, out_rs2_used, out_rd_written, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_fmt, out_imm,
               out_rs1_used, out_rs2_used, out_rd_written, out_illegal
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational format classification, immediate generation and register-use flags.
module decode_imm_gen import rv32i_pkg::*; #(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic            rd_written
);
    logic signed [31:0] imm32;
    logic               rd_nonzero;

    assign rd_nonzero = |instr[11:7];

    // Decode format, build the 32-bit immediate and the use qualifiers.
    always_comb begin
        fmt        = fmt_of(instr[6:0]);
        imm32      = '0;
        illegal    = 1'b0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_written = 1'b0;
        case (fmt)
            FMT_R: begin
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                rd_written = rd_nonzero;
            end
            FMT_I: begin
                imm32      = {{20{instr[31]}}, instr[31:20]};
                rs1_used   = 1'b1;
                rd_written = rd_nonzero;
            end
            FMT_S: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            FMT_B: begin
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            FMT_U: begin
                imm32      = {instr[31:12], 12'b0};
                rd_written = rd_nonzero;
            end
            FMT_J: begin
                imm32      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
                rd_written = rd_nonzero;
            end
            default: illegal = 1'b1;
        endcase
        // Signed source: the size cast sign-extends to XLEN.
        imm = XLEN'(imm32);
    end
endmodule

// File: rtl/decode_stage.sv
// rv32i decode stage: decoder wrapped by a registered main/skid output buffer.
module decode_stage import rv32i_pkg::*; #(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter bit          SKID = 1'b1
) (
    input logic           clock,
    input logic           reset,
    input logic           flush,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_written;
        logic            illegal;
    } entry_t;

    localparam entry_t ResetEntry = '{fmt: FMT_ILLEGAL, default: '0};

    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_rs1_used;
    logic            dec_rs2_used;
    logic            dec_rd_written;
    entry_t          in_entry;

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready;
    logic   accept;
    logic   drain;

    decode_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr      (bus.in_instr),
        .fmt        (dec_fmt),
        .imm        (dec_imm),
        .illegal    (dec_illegal),
        .rs1_used   (dec_rs1_used),
        .rs2_used   (dec_rs2_used),
        .rd_written (dec_rd_written)
    );

    // Assemble the decoded entry for the incoming instruction.
    always_comb begin
        in_entry.pc         = bus.in_pc;
        in_entry.opcode     = bus.in_instr[6:0];
        in_entry.funct3     = bus.in_instr[14:12];
        in_entry.funct7     = bus.in_instr[31:25];
        in_entry.rs1        = bus.in_instr[19:15];
        in_entry.rs2        = bus.in_instr[24:20];
        in_entry.rd         = bus.in_instr[11:7];
        in_entry.fmt        = dec_fmt;
        in_entry.imm        = dec_imm;
        in_entry.rs1_used   = dec_rs1_used;
        in_entry.rs2_used   = dec_rs2_used;
        in_entry.rd_written = dec_rd_written;
        in_entry.illegal    = dec_illegal;
    end

    // Ready: skid occupancy alone with a skid buffer, pass-through of out_ready without one.
    // Flush forces ready so fetch never stalls on a cycle whose input is discarded anyway.
    always_comb begin
        if (SKID) begin
            in_ready = !skid_valid_q || flush;
        end else begin
            in_ready = !main_valid_q || bus.out_ready || flush;
        end
    end

    assign accept = bus.in_valid && in_ready && !flush;
    assign drain  = main_valid_q && bus.out_ready;

    // Buffer next state; flush beats any transfer, skid refills main before new input.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            // in_ready is low here, so no accept can coincide.
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end else if (SKID && accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= ResetEntry;
            skid_q       <= ResetEntry;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = main_valid_q;
    assign bus.out_pc         = main_q.pc;
    assign bus.out_opcode     = main_q.opcode;
    assign bus.out_funct3     = main_q.funct3;
    assign bus.out_funct7     = main_q.funct7;
    assign bus.out_rs1        = main_q.rs1;
    assign bus.out_rs2        = main_q.rs2;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_fmt        = main_q.fmt;
    assign bus.out_imm        = main_q.imm;
    assign bus.out_rs1_used   = main_q.rs1_used;
    assign bus.out_rs2_used   = main_q.rs2_used;
    assign bus.out_rd_written = main_q.rd_written;
    assign bus.out_illegal    = main_q.illegal;
endmodule
